// File: rtl/dram_axi_responder.sv
// dram_axi_responder: AXI4-Lite-style stand-in for off-chip DRAM.
// 256 x 64-bit words. The read and write FSMs are independent, each with one
// outstanding transaction and a programmable response latency.
module dram_axi_responder #(
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 4,
  parameter bit INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_DATA} rstate_t;
  typedef enum logic [1:0] {WS_IDLE, WS_DATA, WS_BWAIT, WS_BRESP} wstate_t;

  rstate_t     rstate;
  wstate_t     wstate;
  logic [7:0]  r_idx, w_idx;
  logic        r_legal, w_legal;
  logic [3:0]  r_cnt, w_cnt;
  logic [63:0] mem [256];
  logic        w_commit;

  // Only the 2 KB window at 0x10000 with 8-byte alignment maps to memory.
  function automatic logic addr_legal(input logic [16:0] a);
    return (a[16:11] == 6'b100000) && (a[2:0] == 3'b000);
  endfunction

  assign AR_READY = (rstate == RS_IDLE);
  assign AW_READY = (wstate == WS_IDLE);
  assign W_READY  = (wstate == WS_DATA);
  // Illegal writes are still handshaken but never touch memory.
  assign w_commit = (wstate == WS_DATA) && W_VALID && w_legal;

  // Read channel: accept address, count down latency, hold data until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate  <= RS_IDLE;
      r_idx   <= '0;
      r_legal <= 1'b0;
      r_cnt   <= '0;
      R_VALID <= 1'b0;
      R_DATA  <= '0;
      R_RESP  <= RESP_OKAY;
    end else begin
      case (rstate)
        RS_IDLE: if (AR_VALID) begin
          r_idx   <= AR_ADDR[10:3];
          r_legal <= addr_legal(AR_ADDR);
          r_cnt   <= 4'(RD_LAT);
          rstate  <= RS_WAIT;
        end
        RS_WAIT: if (r_cnt == 4'd0) begin
          // Sampling mem here sees the pre-edge contents, so a write
          // committing on this same edge is not visible to this read.
          R_DATA  <= r_legal ? mem[r_idx] : 64'h0;
          R_RESP  <= r_legal ? RESP_OKAY : RESP_SLVERR;
          R_VALID <= 1'b1;
          rstate  <= RS_DATA;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        RS_DATA: if (R_READY) begin
          R_VALID <= 1'b0;
          R_DATA  <= '0;
          R_RESP  <= RESP_OKAY;
          rstate  <= RS_IDLE;
        end
        default: rstate <= RS_IDLE;
      endcase
    end
  end

  // Write channel: address first, then data, then latency, then response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate  <= WS_IDLE;
      w_idx   <= '0;
      w_legal <= 1'b0;
      w_cnt   <= '0;
      B_VALID <= 1'b0;
      B_RESP  <= RESP_OKAY;
    end else begin
      case (wstate)
        WS_IDLE: if (AW_VALID) begin
          w_idx   <= AW_ADDR[10:3];
          w_legal <= addr_legal(AW_ADDR);
          wstate  <= WS_DATA;
        end
        WS_DATA: if (W_VALID) begin
          w_cnt  <= 4'(WR_LAT);
          wstate <= WS_BWAIT;
        end
        WS_BWAIT: if (w_cnt == 4'd0) begin
          B_RESP  <= w_legal ? RESP_OKAY : RESP_SLVERR;
          B_VALID <= 1'b1;
          wstate  <= WS_BRESP;
        end else begin
          w_cnt <= w_cnt - 4'd1;
        end
        WS_BRESP: if (B_READY) begin
          B_VALID <= 1'b0;
          B_RESP  <= RESP_OKAY;
          wstate  <= WS_IDLE;
        end
        default: wstate <= WS_IDLE;
      endcase
    end
  end

  generate
    if (INIT_ZERO) begin : g_mem_rst
      // Storage array cleared on reset; written on a legal data handshake.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (w_commit) begin
          mem[w_idx] <= W_DATA;
        end
      end
    end else begin : g_mem_keep
      // Storage array survives reset; written on a legal data handshake.
      always_ff @(posedge clk) begin
        if (w_commit) mem[w_idx] <= W_DATA;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dram_axi_responder.sv
// Self-checking bench for dram_axi_responder: directed scenarios plus a
// randomized read/write mix checked against a flat array memory model.
module tb_dram_axi_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

  int checks = 0;
  int fails  = 0;
  logic [63:0] model [256];

  dram_axi_responder #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic [7:0] i);
    return {5'h10, 1'b0, i, 3'h0};
  endfunction

  // Memory map rule: 2 KB window at 0x10000, 8-byte aligned words.
  function automatic bit legal(input logic [16:0] a);
    return ((int'(a) / 2048) == 32) && ((int'(a) % 8) == 0);
  endfunction

  function automatic int idx_of(input logic [16:0] a);
    return (int'(a) / 8) % 256;
  endfunction

  function automatic logic [8:0] ctl_vec();
    return {AR_READY, AW_READY, W_READY, R_VALID, B_VALID, R_RESP, B_RESP};
  endfunction

  // Full write: AW, then W, then wait for B (B_READY assumed high).
  task automatic do_write(input logic [16:0] a, input logic [63:0] d,
                          output int lat, output logic [1:0] resp);
    int n;
    @(negedge clk); AW_VALID = 1'b1; AW_ADDR = a; n = 0;
    while (!AW_READY && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    AW_VALID = 1'b0; W_VALID = 1'b1; W_DATA = d;
    @(posedge clk); @(negedge clk);
    W_VALID = 1'b0;
    lat = -1; resp = 2'bxx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (B_VALID) begin lat = k; resp = B_RESP; break; end
    end
  endtask

  // Full read: AR, then wait for R (R_READY assumed high).
  task automatic do_read(input logic [16:0] a, output int lat,
                         output logic [63:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk); AR_VALID = 1'b1; AR_ADDR = a; n = 0;
    while (!AR_READY && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    AR_VALID = 1'b0;
    lat = -1; d = 'x; resp = 2'bxx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (R_VALID) begin lat = k; d = R_DATA; resp = R_RESP; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; AR_VALID = 0; AR_ADDR = 0; AW_VALID = 0; AW_ADDR = 0;
    W_VALID = 0; W_DATA = 0; R_READY = 1; B_READY = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (ctl_vec() !== 9'b110000000) begin
      fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl_vec(), 9'b110000000);
    end
    checks++;
    if (R_DATA !== 64'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", R_DATA); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl_vec() !== 9'b110000000) begin
      fails++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl_vec(), 9'b110000000);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [1:0] resp; logic [63:0] d;
    // Data before address must not be accepted.
    @(negedge clk); W_VALID = 1'b1; W_DATA = 64'h1111_2222_3333_4444;
    @(posedge clk); @(negedge clk);
    checks++;
    if (W_READY !== 1'b0) begin fails++; $display("FAIL w_before_aw got=%b exp=0", W_READY); end
    W_VALID = 1'b0;
    do_write(17'h101E0, 64'hDEAD_BEEF_0123_4567, lat, resp);
    model[8'h3C] = 64'hDEAD_BEEF_0123_4567;
    checks++;
    if (lat != WR_LAT + 1) begin fails++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WR_LAT + 1); end
    checks++;
    if (resp !== 2'b00) begin fails++; $display("FAIL wr_resp got=%b exp=00", resp); end
    @(negedge clk);
    checks++;
    if ({B_VALID, B_RESP} !== 3'b000) begin fails++; $display("FAIL b_release got=%b exp=000", {B_VALID, B_RESP}); end
    do_read(17'h101E0, lat, d, resp);
    checks++;
    if (lat != RD_LAT + 1) begin fails++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RD_LAT + 1); end
    checks++;
    if (d !== model[8'h3C] || resp !== 2'b00) begin
      fails++; $display("FAIL rd_data got=%h/%b exp=%h/00", d, resp, model[8'h3C]);
    end
    @(negedge clk);
    checks++;
    if ({R_VALID, R_DATA} !== 65'h0) begin fails++; $display("FAIL r_one_cycle got=%b/%h exp=0/0", R_VALID, R_DATA); end
  endtask

  task automatic test_backpressure();
    int n;
    R_READY = 1'b0;
    @(negedge clk); AR_VALID = 1'b1; AR_ADDR = mk(8'h05);
    @(posedge clk); @(negedge clk); AR_VALID = 1'b0;
    n = 0;
    while (!R_VALID && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (R_VALID !== 1'b1) begin fails++; $display("FAIL bp_timeout got=%b exp=1", R_VALID); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({R_VALID, AR_READY, R_RESP} !== 4'b1000 || R_DATA !== model[5]) begin
        fails++; $display("FAIL bp_hold cyc=%0d got=%b%b%b/%h exp=1000/%h", c, R_VALID, AR_READY, R_RESP, R_DATA, model[5]);
      end
    end
    R_READY = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({R_VALID, AR_READY} !== 2'b01 || R_DATA !== 64'h0) begin
      fails++; $display("FAIL bp_release got=%b%b/%h exp=01/0", R_VALID, AR_READY, R_DATA);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [1:0] resp; logic [63:0] d;
    do_read(17'h08028, lat, d, resp);
    checks++;
    if (resp !== 2'b10 || d !== 64'h0) begin fails++; $display("FAIL bad_prefix_rd got=%b/%h exp=10/0", resp, d); end
    do_write(mk(8'h00), 64'hA5A5_0000_5A5A_FFFF, lat, resp);
    model[0] = 64'hA5A5_0000_5A5A_FFFF;
    do_write(17'h10004, 64'hFFFF_FFFF_FFFF_FFFF, lat, resp);
    checks++;
    if (resp !== 2'b10 || lat != WR_LAT + 1) begin fails++; $display("FAIL misalign_wr got=%b lat=%0d exp=10 lat=%0d", resp, lat, WR_LAT + 1); end
    do_read(mk(8'h00), lat, d, resp);
    checks++;
    if (d !== model[0] || resp !== 2'b00) begin fails++; $display("FAIL misalign_kept got=%h/%b exp=%h/00", d, resp, model[0]); end
  endtask

  // Write to idx 0x10 commits d cycles after the AR handshake; the read
  // captures RD_LAT+1 cycles after it.
  task automatic hazard(input int dly, input logic [63:0] nv, input string nm);
    logic [63:0] exp_d;
    exp_d = (dly == RD_LAT + 1) ? model[8'h10] : nv;
    @(negedge clk); AW_VALID = 1'b1; AW_ADDR = mk(8'h10);
    @(posedge clk); @(negedge clk);
    AW_VALID = 1'b0; AR_VALID = 1'b1; AR_ADDR = mk(8'h10);
    @(posedge clk); @(negedge clk);
    AR_VALID = 1'b0; W_DATA = nv; W_VALID = (dly == 1);
    for (int j = 1; j <= RD_LAT + 1; j++) begin
      @(posedge clk); @(negedge clk);
      W_VALID = (j == dly - 1);
    end
    checks++;
    if (R_VALID !== 1'b1 || R_DATA !== exp_d) begin
      fails++; $display("FAIL %s got=%b/%h exp=1/%h", nm, R_VALID, R_DATA, exp_d);
    end
    model[8'h10] = nv;
    repeat (WR_LAT + 4) @(negedge clk);
  endtask

  task automatic test_hazard();
    int lat; logic [1:0] resp;
    do_write(mk(8'h10), 64'h0101_0101_0101_0101, lat, resp);
    model[8'h10] = 64'h0101_0101_0101_0101;
    hazard(RD_LAT + 1, 64'h0202_0202_0202_0202, "hazard_same_edge");
    hazard(RD_LAT,     64'h0303_0303_0303_0303, "hazard_write_first");
  endtask

  task automatic test_reset_mid();
    int lat; logic [1:0] resp; logic [63:0] d; int seen;
    @(negedge clk); AW_VALID = 1'b1; AW_ADDR = mk(8'h20);
    @(posedge clk); @(negedge clk);
    AW_VALID = 1'b0; W_VALID = 1'b1; W_DATA = 64'h7777_8888_9999_AAAA;
    AR_VALID = 1'b1; AR_ADDR = mk(8'h3C);
    @(posedge clk); @(negedge clk);
    W_VALID = 1'b0; AR_VALID = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl_vec() !== 9'b110000000 || R_DATA !== 64'h0) begin
      fails++; $display("FAIL mid_reset_ctl got=%b/%h exp=110000000/0", ctl_vec(), R_DATA);
    end
    for (int i = 0; i < 256; i++) model[i] = 64'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (R_VALID || B_VALID) seen++; end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL mid_reset_pulse got=%0d exp=0", seen); end
    do_read(mk(8'h20), lat, d, resp);
    checks++;
    if (lat != RD_LAT + 1 || d !== 64'h0 || resp !== 2'b00) begin
      fails++; $display("FAIL after_reset_rd got=%0d/%h/%b exp=%0d/0/00", lat, d, resp, RD_LAT + 1);
    end
    do_write(mk(8'h21), 64'hCAFE_F00D_0000_1234, lat, resp);
    model[8'h21] = 64'hCAFE_F00D_0000_1234;
    checks++;
    if (lat != WR_LAT + 1 || resp !== 2'b00) begin
      fails++; $display("FAIL after_reset_wr got=%0d/%b exp=%0d/00", lat, resp, WR_LAT + 1);
    end
  endtask

  task automatic test_random();
    int lat; logic [1:0] resp, er; logic [63:0] d, wd, ed; logic [16:0] a;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) a = 17'($urandom);
      else a = mk(8'($urandom_range(0, 31)));
      er = legal(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        wd = {$urandom, $urandom};
        do_write(a, wd, lat, resp);
        if (legal(a)) model[idx_of(a)] = wd;
        checks++;
        if (lat != WR_LAT + 1 || resp !== er) begin
          fails++; $display("FAIL rand_wr t=%0d a=%h got=%0d/%b exp=%0d/%b", t, a, lat, resp, WR_LAT + 1, er);
        end
      end else begin
        do_read(a, lat, d, resp);
        ed = legal(a) ? model[idx_of(a)] : 64'h0;
        checks++;
        if (lat != RD_LAT + 1 || resp !== er || d !== ed) begin
          fails++; $display("FAIL rand_rd t=%0d a=%h got=%0d/%b/%h exp=%0d/%b/%h", t, a, lat, resp, d, RD_LAT + 1, er, ed);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 64'h0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_illegal();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
